// File: rtl/pmem_arb_pkg.sv
// rtl/pmem_arb_pkg.sv - shared types and default widths for the pmem arbiter slice
package pmem_arb_pkg;

  localparam int unsigned ARB_ADDR_WIDTH = 32;
  localparam int unsigned ARB_LINE_WIDTH = 256;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_SERVE_I = 2'd1,
    ARB_SERVE_D = 2'd2,
    ARB_DONE    = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/arb_grant_select.sv
// rtl/arb_grant_select.sv - picks the next owner; ARB_ROUND_ROBIN_EN selects round-robin
// instead of fixed dcache priority.
module arb_grant_select
  import pmem_arb_pkg::*;
(
  input  logic       i_req,
  input  logic       d_req,
  input  arb_owner_t last_grant,
  output logic       grant_valid,
  output arb_owner_t grant_owner
);

  assign grant_valid = i_req | d_req;

`ifdef ARB_ROUND_ROBIN_EN
  // On a conflict the side that did not win last time goes next.
  always_comb begin
    grant_owner = OWNER_I;
    if (i_req && d_req) begin
      grant_owner = (last_grant == OWNER_I) ? OWNER_D : OWNER_I;
    end else if (d_req) begin
      grant_owner = OWNER_D;
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    grant_owner = OWNER_I;
    if (d_req) begin
      grant_owner = OWNER_D;
    end
  end
`endif

endmodule

// File: rtl/pmem_arbiter.sv
// rtl/pmem_arbiter.sv - shares the cacheline adaptor between icache and dcache, one owner
// at a time with a DONE turnaround; grant policy set by ARB_ROUND_ROBIN_EN.
module pmem_arbiter
  import pmem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = ARB_ADDR_WIDTH,
  parameter int LINE_WIDTH = ARB_LINE_WIDTH,
  parameter int BE_WIDTH   = LINE_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] i_mem_address,
  input  logic                  i_mem_read,
  output logic [LINE_WIDTH-1:0] i_mem_rdata,
  output logic                  i_mem_resp,
  input  logic [ADDR_WIDTH-1:0] d_mem_address,
  input  logic                  d_mem_read,
  input  logic                  d_mem_write,
  input  logic [BE_WIDTH-1:0]   d_mem_byte_enable,
  input  logic [LINE_WIDTH-1:0] d_mem_wdata,
  output logic [LINE_WIDTH-1:0] d_mem_rdata,
  output logic                  d_mem_resp,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [BE_WIDTH-1:0]   pmem_byte_enable,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  arb_state_t state_q, state_d;
  arb_owner_t last_grant_q, last_grant_d;
  logic       grant_valid;
  arb_owner_t grant_owner;

  arb_grant_select u_grant_select (
    .i_req       (i_mem_read),
    .d_req       (d_mem_read | d_mem_write),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ARB_IDLE: begin
        if (grant_valid) begin
          state_d      = (grant_owner == OWNER_I) ? ARB_SERVE_I : ARB_SERVE_D;
          last_grant_d = grant_owner;
        end
      end
      ARB_SERVE_I, ARB_SERVE_D: begin
        if (pmem_resp) begin
          state_d = ARB_DONE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= OWNER_D;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Requests are masked while rst is high so the adaptor sees nothing during reset.
  always_comb begin
    pmem_address     = '0;
    pmem_read        = 1'b0;
    pmem_write       = 1'b0;
    pmem_byte_enable = '0;
    pmem_wdata       = '0;
    i_mem_resp       = 1'b0;
    d_mem_resp       = 1'b0;
    if (!rst) begin
      case (state_q)
        ARB_SERVE_I: begin
          pmem_address     = i_mem_address;
          pmem_read        = i_mem_read;
          pmem_byte_enable = '1;
          i_mem_resp       = pmem_resp;
        end
        ARB_SERVE_D: begin
          pmem_address     = d_mem_address;
          pmem_read        = d_mem_read & ~d_mem_write;
          pmem_write       = d_mem_write;
          pmem_byte_enable = d_mem_byte_enable;
          pmem_wdata       = d_mem_wdata;
          d_mem_resp       = pmem_resp;
        end
        default: ;
      endcase
    end
  end

  assign i_mem_rdata = pmem_rdata;
  assign d_mem_rdata = pmem_rdata;

endmodule

// File: tb/tb_pmem_arbiter.sv
// tb/tb_pmem_arbiter.sv - randomized scoreboard bench for pmem_arbiter
module tb_pmem_arbiter;
  localparam int AW = 32;
  localparam int LW = 256;
  localparam int BW = LW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] i_mem_address;
  logic          i_mem_read;
  logic [LW-1:0] i_mem_rdata;
  logic          i_mem_resp;
  logic [AW-1:0] d_mem_address;
  logic          d_mem_read;
  logic          d_mem_write;
  logic [BW-1:0] d_mem_byte_enable;
  logic [LW-1:0] d_mem_wdata;
  logic [LW-1:0] d_mem_rdata;
  logic          d_mem_resp;
  logic [AW-1:0] pmem_address;
  logic          pmem_read;
  logic          pmem_write;
  logic [BW-1:0] pmem_byte_enable;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;

  always #5 clk = ~clk;

  pmem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .BE_WIDTH(BW)) dut (
    .clk(clk), .rst(rst),
    .i_mem_address(i_mem_address), .i_mem_read(i_mem_read),
    .i_mem_rdata(i_mem_rdata), .i_mem_resp(i_mem_resp),
    .d_mem_address(d_mem_address), .d_mem_read(d_mem_read), .d_mem_write(d_mem_write),
    .d_mem_byte_enable(d_mem_byte_enable), .d_mem_wdata(d_mem_wdata),
    .d_mem_rdata(d_mem_rdata), .d_mem_resp(d_mem_resp),
    .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_byte_enable(pmem_byte_enable), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int timeouts = 0;
  int i_resp_cnt = 0;
  int d_resp_cnt = 0;
  bit run_rand = 1'b0;
  bit adapt_en = 1'b1;
  bit stale = 1'b0;
  logic [LW-1:0] i_q[$];
  logic [LW-1:0] d_q[$];

  // Reference model: owner (-1 none, 0 I, 1 D), first serving cycle, first IDLE cycle.
  int owner = -1;
  int serve_from = 0;
  int idle_at = 0;
  int last = 1;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
    line_of = {8{a ^ 32'h5A5A_0000}};
  endfunction

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s cycle %0d: got unexpected event expected none", name, cyc);
  endtask

  // Monitor: cycle-level model from the timing rules plus per-port response scoreboards.
  initial begin
    logic          e_rd, e_wr, e_ir, e_dr, ir, dr, active;
    logic [AW-1:0] e_addr;
    logic [BW-1:0] e_be;
    logic [LW-1:0] e_wd;
    int            w;
    forever begin
      @(negedge clk);
      if (rst) begin
        owner = -1; idle_at = cyc + 1; last = 1;
        chk("reset_outputs", {pmem_read, pmem_write, pmem_address, pmem_byte_enable,
            pmem_wdata, i_mem_resp, d_mem_resp}, '0);
      end else begin
        active = (owner >= 0) && (cyc >= serve_from);
        e_rd = 0; e_wr = 0; e_addr = '0; e_be = '0; e_wd = '0;
        if (active && owner == 0) begin
          e_rd = i_mem_read; e_addr = i_mem_address; e_be = '1;
        end else if (active && owner == 1) begin
          e_wr = d_mem_write; e_rd = d_mem_read && !d_mem_write;
          e_addr = d_mem_address; e_be = d_mem_byte_enable; e_wd = d_mem_wdata;
        end
        chk("pmem_request", {pmem_read, pmem_write, pmem_address, pmem_byte_enable, pmem_wdata},
            {e_rd, e_wr, e_addr, e_be, e_wd});
        e_ir = active && owner == 0 && pmem_resp;
        e_dr = active && owner == 1 && pmem_resp;
        chk("resp_routing", {i_mem_resp, d_mem_resp}, {e_ir, e_dr});
        chk("rdata_passthrough", {i_mem_rdata, d_mem_rdata}, {pmem_rdata, pmem_rdata});
        if (i_mem_resp) begin
          if (i_q.size() == 0) fail("i_unexpected_resp");
          else chk("i_rdata", i_mem_rdata, i_q.pop_front());
          i_resp_cnt++;
        end
        if (d_mem_resp) begin
          if (d_q.size() == 0) fail("d_unexpected_resp");
          else chk("d_rdata", d_mem_rdata, d_q.pop_front());
          d_resp_cnt++;
        end
        if (active && pmem_resp) begin
          owner = -1; idle_at = cyc + 2;
        end else if (owner < 0 && cyc >= idle_at) begin
          ir = i_mem_read;
          dr = d_mem_read | d_mem_write;
          if (ir || dr) begin
`ifdef ARB_ROUND_ROBIN_EN
            if (ir && dr) w = (last == 0) ? 1 : 0;
            else w = dr ? 1 : 0;
`else
            w = dr ? 1 : 0;
`endif
            owner = w; serve_from = cyc + 1; last = w;
          end
        end
      end
    end
  end

  // Adaptor model: random 0..4 extra cycles, one-cycle resp, rdata derived from the address.
  initial begin
    int cnt, lat;
    cnt = 0; lat = 0;
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(posedge clk); #2;
      if (!adapt_en) begin
        pmem_resp = stale;
      end else if (pmem_resp) begin
        pmem_resp = 1'b0; cnt = 0;
      end else if (pmem_read || pmem_write) begin
        if (cnt == 0) lat = $urandom_range(0, 4);
        if (cnt >= lat) begin
          pmem_resp = 1'b1; pmem_rdata = line_of(pmem_address);
        end else begin
          cnt++; pmem_rdata[31:0] = $urandom();
        end
      end else begin
        pmem_rdata[31:0] = $urandom();
      end
    end
  end

  task automatic i_req_task();
    logic [AW-1:0] a;
    int t, base;
    while (run_rand) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      @(posedge clk); #1;
      if (!run_rand) break;
      a = $urandom() & 32'hFFFF_FFE0;
      i_mem_address = a; i_mem_read = 1'b1;
      base = i_resp_cnt;
      i_q.push_back(line_of(a));
      t = 0;
      while (i_resp_cnt == base && t < 200) begin @(posedge clk); #1; t++; end
      if (i_resp_cnt == base) timeouts++;
      i_mem_read = 1'b0;
    end
  endtask

  task automatic d_req_task();
    logic [AW-1:0] a;
    logic [LW-1:0] wd;
    int t, base, kind;
    while (run_rand) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      @(posedge clk); #1;
      if (!run_rand) break;
      a = $urandom() & 32'hFFFF_FFE0;
      for (int k = 0; k < 8; k++) wd[k*32 +: 32] = $urandom();
      kind = $urandom_range(0, 3);
      d_mem_address = a; d_mem_wdata = wd; d_mem_byte_enable = $urandom();
      d_mem_read = (kind == 0 || kind == 1 || kind == 3);
      d_mem_write = (kind >= 2);
      base = d_resp_cnt;
      d_q.push_back(line_of(a));
      t = 0;
      while (d_resp_cnt == base && t < 200) begin @(posedge clk); #1; t++; end
      if (d_resp_cnt == base) timeouts++;
      d_mem_read = 1'b0; d_mem_write = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    i_mem_address = '0; i_mem_read = 1'b0;
    d_mem_address = '0; d_mem_read = 1'b0; d_mem_write = 1'b0;
    d_mem_byte_enable = '0; d_mem_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", {pmem_read, pmem_write, pmem_address, i_mem_resp, d_mem_resp}, '0);

    run_rand = 1'b1;
    fork
      i_req_task();
      d_req_task();
      begin repeat (3000) @(posedge clk); run_rand = 1'b0; end
    join
    chk("no_timeouts", timeouts, 0);
    chk("i_queue_drained", i_q.size(), 0);
    chk("d_queue_drained", d_q.size(), 0);

    // Reset in the middle of a dcache writeback, then a stale adaptor resp.
    adapt_en = 1'b0;
    @(posedge clk); #1;
    d_mem_address = 32'h0000_2040; d_mem_byte_enable = '1;
    d_mem_wdata = {8{32'h1234_5678}}; d_mem_write = 1'b1;
    @(negedge clk);
    chk("rst_test_idle_c0", {pmem_write, pmem_read}, 2'b00);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_test_write_c1", {pmem_write, pmem_read, pmem_address, pmem_wdata},
        {1'b1, 1'b0, 32'h0000_2040, {8{32'h1234_5678}}});
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; d_mem_write = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_test_write_dropped", {pmem_write, pmem_read, pmem_address}, '0);
    stale = 1'b1;
    @(negedge clk);
    chk("stale_resp_ignored", {pmem_resp, i_mem_resp, d_mem_resp}, 3'b100);
    stale = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    wait (cyc >= 20000);
    $display("FAIL watchdog: got cycle %0d expected completion before 20000", cyc);
    $fatal(1);
  end

endmodule

// File: doc/pmem_arbiter.md
# pmem_arbiter

Two-port arbiter sharing the single cacheline adaptor, and through it physical memory, between the instruction cache and the data cache. Each cache issues whole-line requests. The arbiter grants one owner at a time, forwards that owner's request unchanged to the adaptor, and routes the response back. A one-cycle turnaround state separates transactions, so a requester's still-asserted request is never re-granted.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte address width on all ports
- LINE_WIDTH, 256, cacheline data width
- BE_WIDTH, LINE_WIDTH/8, byte-enable width

Ports:
- clk  in  1  single clock, all state on posedge
- rst  in  1  synchronous, active-high reset
- i_mem_address  in  ADDR_WIDTH  icache line address
- i_mem_read  in  1  icache read request; held until i_mem_resp
- i_mem_rdata  out  LINE_WIDTH  line returned to icache
- i_mem_resp  out  1  icache transaction complete
- d_mem_address  in  ADDR_WIDTH  dcache line address
- d_mem_read  in  1  dcache read request; held until d_mem_resp
- d_mem_write  in  1  dcache writeback request; held until d_mem_resp
- d_mem_byte_enable  in  BE_WIDTH  dcache write byte enables
- d_mem_wdata  in  LINE_WIDTH  dcache writeback line
- d_mem_rdata  out  LINE_WIDTH  line returned to dcache
- d_mem_resp  out  1  dcache transaction complete
- pmem_address  out  ADDR_WIDTH  to cacheline adaptor
- pmem_read  out  1  to cacheline adaptor
- pmem_write  out  1  to cacheline adaptor
- pmem_byte_enable  out  BE_WIDTH  to cacheline adaptor
- pmem_wdata  out  LINE_WIDTH  to cacheline adaptor
- pmem_rdata  in  LINE_WIDTH  from cacheline adaptor
- pmem_resp  in  1  from cacheline adaptor

## Operation
- States: IDLE, SERVE_I, SERVE_D, DONE.
- IDLE:
  - Forwards nothing: pmem_read, pmem_write and pmem_address are 0.
  - Samples i_req = i_mem_read and d_req = d_mem_read|d_mem_write.
  - Moves to SERVE_I or SERVE_D per the grant rule; stays in IDLE if neither requests.
- SERVE_I:
  - pmem_address = i_mem_address, pmem_read = i_mem_read, pmem_write = 0, pmem_byte_enable = all ones, pmem_wdata = 0.
  - i_mem_resp = pmem_resp combinationally.
  - On pmem_resp, moves to DONE.
- SERVE_D:
  - All d_* request fields pass through combinationally.
  - d_mem_resp = pmem_resp.
  - If d_mem_read and d_mem_write are both high, only the write is forwarded.
  - On pmem_resp, moves to DONE.
- DONE:
  - Forwards nothing for one cycle, then moves to IDLE.
- i_mem_rdata and d_mem_rdata are both driven by pmem_rdata at all times. Only the owner's resp qualifies the data.
- Dropping a request before resp is a protocol violation. The arbiter remains in SERVE until pmem_resp regardless.
- The non-owner's resp is always 0. A pmem_resp arriving in IDLE or DONE is ignored.

## Timing
- Reset: state = IDLE, last-grant register = D.
  - All outputs are 0 except i/d_mem_rdata, which follow pmem_rdata.
- Grant latency:
  - Request first visible in IDLE at cycle N; pmem request asserted from cycle N+1.
  - pmem_resp at cycle M gives owner resp at cycle M; DONE at M+1; IDLE at M+2.
  - Earliest next grant is at M+3.
- Minimum overhead per transaction is 2 cycles beyond adaptor latency.
- Grant rule without the macro: fixed priority, dcache over icache on simultaneous requests.
- The last-grant register updates on every IDLE to SERVE transition.
- rst asserted mid-transaction returns to IDLE on the next edge, with all requests dropped in that cycle. The adaptor sees the same rst and aborts.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - On simultaneous i_req and d_req in IDLE, the requester not recorded in last-grant wins.
  - Lone requests are granted immediately.
  - The first simultaneous conflict after reset goes to I.
- ARB_ROUND_ROBIN_EN undefined:
  - Fixed dcache priority.
  - The last-grant register exists but does not affect grants.

## Structure
- Shared package pmem_arb_pkg holds:
  - arb_state_t {ARB_IDLE, ARB_SERVE_I, ARB_SERVE_D, ARB_DONE}
  - arb_owner_t {OWNER_I, OWNER_D}
  - default LINE_WIDTH/ADDR_WIDTH constants.
- One sub-module, arb_grant_select: combinational; inputs i_req, d_req, last-grant; outputs grant_valid and grant_owner. The round-robin/priority macro lives only there.
- The output mux and FSM stay in pmem_arbiter.

## Test plan
- Icache-only read:
  - Stimulus: i_mem_read=1, address 0x0000_1000 at cycle 0; adaptor resp at cycle 5 with rdata 0xA5…A5.
  - Required: pmem_read=1 on cycles 1–5; i_mem_resp=1 only on cycle 5; idle cycles 6–7; d_mem_resp never asserted.
- Dcache writeback:
  - Stimulus: d_mem_write=1, address 0x0000_2040, BE all ones, wdata 0x1234…; resp at cycle 4.
  - Required: pmem_write/wdata/byte_enable match inputs on cycles 1–4; pmem_read=0.
- Simultaneous requests, macro off:
  - Stimulus: both request at cycle 0.
  - Required: D granted first; I granted at resp_D+3.
- Simultaneous requests, ARB_ROUND_ROBIN_EN on, repeated back-to-back conflicts:
  - Required: grants alternate I, D, I, D.
- Reset mid-SERVE_D:
  - Stimulus: rst=1 for one cycle at cycle 3.
  - Required: pmem_write=0 at cycle 4; state IDLE; a stale pmem_resp at cycle 5 produces no i/d resp.
